// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, parity modes
// and the line idle level.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each period.
// Restarting on every state entry keeps each bit exactly CLK_DIV cycles long.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmit stage that pops bytes from a registered-output FIFO and sends
// start bit, LSB-first data, optional parity and stop bit(s) on tx.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DWIDTH     = 8,
   parameter int CLK_DIV    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DWIDTH-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int              BIW       = $clog2(DWIDTH + 1);
   localparam int              SCW       = $clog2(2 * CLK_DIV);
   localparam logic [BIW-1:0]  BIT_LAST  = BIW'(DWIDTH - 1);
   localparam logic [SCW-1:0]  STOP_LAST = SCW'(STOP_BITS * CLK_DIV - 1);
   localparam logic [SCW-1:0]  STOP_PRE  = SCW'(STOP_BITS * CLK_DIV - 2);
   localparam logic            PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   uart_state_t       state, state_next;
   logic [DWIDTH-1:0] shreg, shreg_next;
   logic [BIW-1:0]    bit_idx, bit_idx_next;
   logic [SCW-1:0]    stop_cnt, stop_cnt_next;
   logic              parity_bit, parity_next;
   logic              tx_next, rd_en_next, busy_next, done_next;
   logic              tick, clear;

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      shreg_next    = shreg;
      bit_idx_next  = bit_idx;
      stop_cnt_next = '0;
      parity_next   = parity_bit;
      done_next     = 1'b0;
      rd_en_next    = 1'b0;

      unique case (state)
         IDLE: ;
         // First FETCH cycle is the pop; data is valid once the strobe has dropped.
         FETCH: begin
            if (!fifo_rd_en) begin
               shreg_next  = fifo_data;
               parity_next = (^fifo_data) ^ PAR_MODE;
               state_next  = START;
            end
         end
         START: begin
            if (tick) begin
               bit_idx_next = '0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_next = shreg >> 1;
               if (bit_idx == BIT_LAST) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx + BIW'(1);
               end
            end
         end
         PARITY: begin
            if (tick) state_next = STOP;
         end
         STOP: begin
            done_next = (stop_cnt == STOP_PRE);
            if (stop_cnt == STOP_LAST) begin
               state_next = IDLE;
            end else begin
               stop_cnt_next = stop_cnt + SCW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      // Launch check runs on the edge that retires STOP, giving a frame period of F+2.
      if (state_next == IDLE && tx_en && !fifo_empty) begin
         state_next = FETCH;
         rd_en_next = 1'b1;
      end

      busy_next = (state_next != IDLE);
      clear     = (state_next != state);

      unique case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shreg_next[0];
         PARITY:  tx_next = parity_next;
         default: tx_next = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         stop_cnt   <= '0;
         parity_bit <= 1'b0;
         tx         <= LINE_IDLE;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         shreg      <= shreg_next;
         bit_idx    <= bit_idx_next;
         stop_cnt   <= stop_cnt_next;
         parity_bit <= parity_next;
         tx         <= tx_next;
         fifo_rd_en <= rd_en_next;
         busy       <= busy_next;
         frame_done <= done_next;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO models feed the DUTs, outputs are traced per
// cycle at the falling edge, and expectations are checked against cycle offsets from each pop.
module tb_fifo_uart_tx;

   localparam int TR = 4096;

   logic clk = 1'b0;
   logic rst;
   logic tx_en;

   logic       fifo_empty, fifo_rd_en, tx, busy, frame_done;
   logic [7:0] fifo_data = 8'h00;

   logic       empty_p, rd_pe, rd_po, tx_e, tx_o, busy_e, busy_o, done_e, done_o;
   logic [7:0] data_p = 8'h00;

   logic [7:0] mem   [16];
   logic [7:0] mem_p [16];
   int wr_ptr = 0, rd_ptr = 0, wr_p = 0, rd_p = 0;

   logic tr_tx [TR], tr_rd [TR], tr_busy [TR], tr_done [TR];
   logic tr_txe [TR], tr_txo [TR], tr_rdp [TR], tr_done_e [TR], tr_done_o [TR];

   int gcyc = 0;
   int bad_pops = 0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DWIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done));

   fifo_uart_tx #(.DWIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_p), .fifo_data(data_p),
      .fifo_rd_en(rd_pe), .tx(tx_e), .busy(busy_e), .frame_done(done_e));

   fifo_uart_tx #(.DWIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_p), .fifo_data(data_p),
      .fifo_rd_en(rd_po), .tx(tx_o), .busy(busy_o), .frame_done(done_o));

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign empty_p    = (wr_p == rd_p);

   // Registered-output FIFO models: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      gcyc <= gcyc + 1;
      if ((fifo_rd_en && fifo_empty) || ((rd_pe || rd_po) && empty_p)) bad_pops <= bad_pops + 1;
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr % 16];
         rd_ptr    <= rd_ptr + 1;
      end
      if (rd_pe) begin
         data_p <= mem_p[rd_p % 16];
         rd_p   <= rd_p + 1;
      end
   end

   always @(negedge clk) begin
      if (gcyc < TR) begin
         tr_tx[gcyc]     = tx;
         tr_rd[gcyc]     = fifo_rd_en;
         tr_busy[gcyc]   = busy;
         tr_done[gcyc]   = frame_done;
         tr_txe[gcyc]    = tx_e;
         tr_txo[gcyc]    = tx_o;
         tr_rdp[gcyc]    = rd_pe;
         tr_done_e[gcyc] = done_e;
         tr_done_o[gcyc] = done_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 16] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic push_p(input logic [7:0] d);
      mem_p[wr_p % 16] = d;
      wr_p = wr_p + 1;
   endtask

   function automatic int count_pops(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (tr_rd[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic logic [7:0] decode(input int p);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = tr_tx[p + 2 + (1 + k) * 4 + 2];
      return r;
   endfunction

   // Frame of 8N1 at 4 clk/bit: start, d[0]..d[7], stop, each 4 cycles from pop+2.
   task automatic check_frame(input string tag, input int p, input logic [7:0] d);
      logic [9:0] bits;
      bits = {1'b1, d, 1'b0};
      check({tag, "_fetch_idle"}, tr_tx[p + 1], 1);
      for (int b = 0; b < 10; b++)
         for (int j = 0; j < 4; j++)
            check($sformatf("%s_bit%0d_c%0d", tag, b, j), tr_tx[p + 2 + b * 4 + j], bits[b]);
      check({tag, "_done40"}, tr_done[p + 40], 0);
      check({tag, "_done41"}, tr_done[p + 41], 1);
      check({tag, "_busy0"},  tr_busy[p], 1);
      check({tag, "_busy41"}, tr_busy[p + 41], 1);
   endtask

   initial begin
      int e, p, x, r;
      rst   = 1'b1;
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx",   tx, 1);
      check("rst_rd",   fifo_rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      rst   = 1'b0;
      tx_en = 1'b1;

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check($sformatf("idle_%0d", i), {tx, fifo_rd_en, busy}, 3'b100);
      end

      // Single word 0xA5
      push(8'hA5);
      e = gcyc; p = e + 1;
      repeat (50) @(negedge clk);
      check("a5_pop_latency", tr_rd[p], 1);
      check("a5_pop_once", count_pops(e - 5, e + 48), 1);
      check_frame("a5", p, 8'hA5);
      check("a5_busy42", tr_busy[p + 42], 0);
      check("a5_done42", tr_done[p + 42], 0);

      // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
      push_p(8'h07);
      e = gcyc; p = e + 1;
      repeat (55) @(negedge clk);
      check("par_pop", tr_rdp[p], 1);
      check("par_start", tr_txe[p + 2], 0);
      check("par_d7", tr_txe[p + 37], 0);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("par_even_c%0d", j), tr_txe[p + 38 + j], 1);
         check($sformatf("par_odd_c%0d", j),  tr_txo[p + 38 + j], 0);
         check($sformatf("par_stop_c%0d", j), tr_txo[p + 42 + j], 1);
      end
      check("par_even_done41", tr_done_e[p + 41], 0);
      check("par_even_done45", tr_done_e[p + 45], 1);
      check("par_odd_done45",  tr_done_o[p + 45], 1);

      // Three queued words, back to back
      push(8'h00); push(8'hFF); push(8'h3C);
      e = gcyc; p = e + 1;
      repeat (135) @(negedge clk);
      check("b2b_pops", count_pops(p, p + 130), 3);
      check("b2b_pop42", tr_rd[p + 42], 1);
      check("b2b_pop84", tr_rd[p + 84], 1);
      check_frame("b2b0", p, 8'h00);
      check_frame("b2b1", p + 42, 8'hFF);
      check_frame("b2b2", p + 84, 8'h3C);
      for (int f = 0; f < 2; f++) begin
         check($sformatf("b2b_gap%0d_a", f), tr_tx[p + f * 42 + 42], 1);
         check($sformatf("b2b_gap%0d_b", f), tr_tx[p + f * 42 + 43], 1);
      end
      check("b2b_dec0", decode(p), 8'h00);
      check("b2b_dec1", decode(p + 42), 8'hFF);
      check("b2b_dec2", decode(p + 84), 8'h3C);
      check("b2b_busy_end", tr_busy[p + 126], 0);

      // tx_en dropped in cycle 10 with two words queued
      push(8'h5A); push(8'hC3);
      e = gcyc; p = e + 1;
      repeat (11) @(negedge clk);
      tx_en = 1'b0;
      repeat (80) @(negedge clk);
      check("txen_pops", count_pops(p, p + 89), 1);
      check("txen_done41", tr_done[p + 41], 1);
      check("txen_dec", decode(p), 8'h5A);
      check("txen_busy42", tr_busy[p + 42], 0);
      tx_en = 1'b1;
      x = gcyc;
      repeat (50) @(negedge clk);
      check("txen_resume_pop", tr_rd[x + 1], 1);
      check("txen_resume_dec", decode(x + 1), 8'hC3);

      // Asynchronous reset in cycle 20 (data bit 3 of 0x96 = 0)
      push(8'h96);
      e = gcyc; p = e + 1;
      repeat (21) @(negedge clk);
      check("arst_pre_tx", tx, 0);
      rst = 1'b1;
      #1;
      check("arst_tx",   tx, 1);
      check("arst_busy", busy, 0);
      check("arst_done", frame_done, 0);
      push(8'hE1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      r = gcyc;
      repeat (50) @(negedge clk);
      check("arst_no_early_pop", tr_rd[r], 0);
      check("arst_pop", tr_rd[r + 1], 1);
      check_frame("arst_frame", r + 1, 8'hE1);

      check("no_pop_while_empty", bad_pops, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO and drives an asynchronous UART line. It sits directly downstream of the FIFO:
- watches the FIFO's `empty` flag;
- issues single-cycle `rd_en` pops;
- captures the registered `data_out` one cycle later;
- serializes each word as start bit, data LSB-first, optional parity, then stop bit(s).

The block owns all flow control toward the FIFO, so the FIFO never sees a pop while empty.

## Interface
Parameters:
- `DWIDTH`, 8: data bits per frame; must match the FIFO data width.
- `CLK_DIV`, 16: clk cycles per bit period; ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bit periods; 1 or 2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `tx_en`  in  1  permits starting new frames; a frame in progress always completes
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  DWIDTH  FIFO `data_out`, valid the cycle after `fifo_rd_en`
- `fifo_rd_en`  out  1  FIFO pop strobe, single-cycle
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high from the `fifo_rd_en` cycle until the end of the last stop bit
- `frame_done`  out  1  one-cycle pulse in the last cycle of the final stop bit

## Operation
- All outputs are registered.
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0; FSM in IDLE; counters at 0.
- FSM states: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - If `tx_en` && !`fifo_empty`: assert `fifo_rd_en` for exactly one cycle, set `busy`, go to FETCH.
  - Otherwise stay in IDLE with `tx`=1.
- FETCH (1 cycle): latch `fifo_data` into the shift register and compute parity (XOR of the data bits, inverted when `PARITY_ODD`), then go to START.
- START: `tx`=0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0 for CLK_DIV cycles, then shift right.
  - After DWIDTH bits, go to PARITY if `PARITY_EN`, else go to STOP.
- PARITY: `tx` = parity bit for CLK_DIV cycles, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×CLK_DIV cycles.
  - `frame_done` pulses in the final cycle.
  - Then go to IDLE.
- Counter widths:
  - Baud counter: $clog2(CLK_DIV) bits; counts 0..CLK_DIV-1 and wraps.
  - Bit index: $clog2(DWIDTH+1) bits.
  - Stop counter: covers up to 2×CLK_DIV.
- Boundary conditions:
  - `fifo_rd_en` is never asserted while `fifo_empty`=1 and never more than once per frame.
  - `fifo_data` is sampled only in FETCH; later changes on it are ignored.
  - `fifo_empty` and `tx_en` are ignored outside IDLE.
  - If `tx_en` drops mid-frame, the frame completes and no further pop is issued.
  - Async `rst` mid-frame: `tx` goes to 1 immediately and the frame is abandoned. The popped word is lost; this is accepted.

## Timing
- Cycle numbering starts at the `fifo_rd_en` cycle, which is cycle 0.
- Frame on the line:
  - FETCH occupies cycle 1.
  - The start bit is driven from cycle 2.
  - Data bit k occupies cycles 2+(1+k)×CLK_DIV through 2+(2+k)×CLK_DIV−1.
- Frame length: F = (1+DWIDTH+PARITY_EN+STOP_BITS)×CLK_DIV.
- `frame_done` is asserted in cycle F+1; `busy` deasserts after cycle F+1.
- Back-to-back frames (FIFO non-empty): the next `fifo_rd_en` comes in cycle F+2. The line idles high for 2 extra cycles between frames, so the frame period is F+2.
- Latency from `fifo_empty` falling (in IDLE) to `fifo_rd_en`: 1 cycle.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, FETCH, START, DATA, PARITY, STOP.
  - Parity mode constants.
  - Line idle level constant (1).
- Sub-module `uart_baud_gen`:
  - Parameterized on CLK_DIV.
  - `clear` input, restarted on each state entry.
  - Outputs a `tick` in the last cycle of each bit period.
- The FSM, shift register and parity logic stay in `fifo_uart_tx`.

## Test plan
Unless stated otherwise, tests use DWIDTH=8, CLK_DIV=4, no parity, STOP_BITS=1.

- Reset, then hold `fifo_empty`=1 for 50 cycles → `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout.
- Single word 0xA5 (`fifo_empty` falls once, FIFO model returns 0xA5 the cycle after the pop):
  - `fifo_rd_en` is high in cycle 0 only.
  - `tx` bits are 0,1,0,1,0,0,1,0,1,1, each 4 cycles, starting in cycle 2.
  - `frame_done` is high in cycle 41.
- PARITY_EN=1, PARITY_ODD=0, word 0x07 → parity bit 1 in cycles 38–41; `frame_done` in cycle 45. With PARITY_ODD=1 → parity bit 0.
- Three words 0x00, 0xFF, 0x3C queued:
  - Pops occur in cycles 0, 42, 84.
  - `tx` is high for exactly 6 cycles between each stop-bit start and the next start bit.
  - Decoded bytes match the input in order.
- `tx_en` dropped in cycle 10 while two words are queued → the first frame completes, `frame_done` at cycle 41, and no second `fifo_rd_en` is issued while `tx_en`=0.
- `rst` asserted asynchronously in cycle 20 (mid DATA) → `tx`=1 the same cycle. After release with `fifo_empty`=0, a fresh pop and a full frame follow the normal timing.
